fft_plane_collector: RTL and testbench

- Consumer end of the FFT image stream: receives 512-bit cachelines, each one plane (real or imag) of one 4x4 complex tile.
- Collects the 8 planes (4 tiles x {r,i}) that make up one frame into a ping-pong frame buffer.
- Presents each complete frame (4096 bits) to the downstream inverse-FFT / multiply stage over a valid/ready handshake.
- Raises upstream backpressure when both buffers are full.

---
 rtl/fft_plane_collector_if.sv | 41 ++++
 rtl/fft_plane_collector.sv | 117 +++++++++++
 tb/tb_fft_plane_collector.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_plane_collector_if.sv
// Bus bundle for fft_plane_collector: the cacheline input stream and the frame output handshake.
// Optional plane tagging is compiled in with FFT_PLANE_COLLECTOR_TAG_CHECK_EN.
interface fft_plane_collector_if #(
    parameter int unsigned NUM_PLANES = 8,
    parameter int unsigned PLANE_W    = 512
);
    localparam int unsigned FRAME_W = NUM_PLANES * PLANE_W;

    logic               input_valid;
    logic [PLANE_W-1:0] cacheline_in;
    logic [31:0]        ctx_length;
    logic               input_full;
    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_out;
    logic [31:0]        frame_index;
    logic               done;
    logic               overflow;
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
    logic [2:0]         plane_tag;
    logic               tag_error;

    modport master (
        output input_valid, cacheline_in, ctx_length, frame_ready, plane_tag,
        input  input_full, frame_valid, frame_out, frame_index, done, overflow, tag_error
    );
    modport slave (
        input  input_valid, cacheline_in, ctx_length, frame_ready, plane_tag,
        output input_full, frame_valid, frame_out, frame_index, done, overflow, tag_error
    );
`else
    modport master (
        output input_valid, cacheline_in, ctx_length, frame_ready,
        input  input_full, frame_valid, frame_out, frame_index, done, overflow
    );
    modport slave (
        input  input_valid, cacheline_in, ctx_length, frame_ready,
        output input_full, frame_valid, frame_out, frame_index, done, overflow
    );
`endif
endinterface

// File: rtl/fft_plane_collector.sv
// Collects eight 512-bit planes per frame into a ping-pong buffer and hands
// complete 4096-bit frames downstream over valid/ready.
// Optional feature macro: FFT_PLANE_COLLECTOR_TAG_CHECK_EN (plane tag check/resync).
module fft_plane_collector #(
    parameter int unsigned NUM_PLANES = 8,
    parameter int unsigned PLANE_W    = 512
) (
    input  logic               clk,
    input  logic               reset,
    fft_plane_collector_if.slave bus
);
    localparam int unsigned PIDX_W = $clog2(NUM_PLANES);

    logic                               wsel;
    logic                               rsel;
    logic [PIDX_W-1:0]                  plane;
    logic [1:0]                         full;
    logic [31:0]                        frame_count;
    logic [31:0]                        ctx_len;
    logic                               done_q;
    logic                               overflow_q;
    logic [NUM_PLANES-1:0][PLANE_W-1:0] frame_buf [2];
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
    logic                               tag_error_q;
`endif

    logic              idle;
    logic [31:0]       ctx_eff;
    logic [31:0]       filled;
    logic              quota_hit;
    logic              accept;
    logic              reject;
    logic              hs;
    logic [PIDX_W-1:0] slot;
    logic              last;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;

    // Accept/release decisions; a new frame may only start while the frame quota has room.
    always_comb begin
        idle      = (frame_count == 32'd0) && (plane == '0) && (full == 2'b00);
        ctx_eff   = idle ? bus.ctx_length : ctx_len;
        filled    = frame_count + 32'(full[0]) + 32'(full[1]);
        quota_hit = (ctx_eff != 32'd0) && (plane == '0) && (filled >= ctx_eff);
        accept    = bus.input_valid & ~full[wsel] & ~done_q & ~quota_hit;
        reject    = bus.input_valid & ~accept;
        hs        = full[rsel] & bus.frame_ready;
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
        slot      = PIDX_W'(bus.plane_tag);
`else
        slot      = plane;
`endif
        last      = (slot == PIDX_W'(NUM_PLANES - 1));
        full_set  = {accept & last & wsel, accept & last & ~wsel};
        full_clr  = {hs & rsel, hs & ~rsel};
    end

    // Control state: plane counter, buffer selects, occupancy, frame counting and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wsel        <= 1'b0;
            rsel        <= 1'b0;
            plane       <= '0;
            full        <= 2'b00;
            frame_count <= 32'd0;
            ctx_len     <= 32'd0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
            tag_error_q <= 1'b0;
`endif
        end else begin
            if (idle) begin
                ctx_len <= bus.ctx_length;
            end
            if (accept) begin
                plane <= last ? '0 : slot + PIDX_W'(1);
                if (last) begin
                    wsel <= ~wsel;
                end
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
                if (slot != plane) begin
                    tag_error_q <= 1'b1;
                end
`endif
            end
            full <= (full & ~full_clr) | full_set;
            if (hs) begin
                rsel        <= ~rsel;
                frame_count <= frame_count + 32'd1;
                if ((ctx_len != 32'd0) && (frame_count + 32'd1 == ctx_len)) begin
                    done_q <= 1'b1;
                end
            end
            if (reject) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_buf[wsel][slot] <= bus.cacheline_in;
        end
    end

    assign bus.input_full  = full[wsel];
    assign bus.frame_valid = full[rsel];
    assign bus.frame_out   = frame_buf[rsel];
    assign bus.frame_index = frame_count;
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
    assign bus.tag_error   = tag_error_q;
`endif
endmodule

// File: tb/tb_fft_plane_collector.sv
// Self-checking bench for fft_plane_collector: directed scenarios plus random traffic
// against a frame-queue reference model.
module tb_fft_plane_collector;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fft_plane_collector_if bus ();

    fft_plane_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of completed frames awaiting delivery, plus the partial frame.
    logic [4095:0] mq [$];
    logic [511:0]  part [8];
    int            part_n;
    int            delivered;
    bit            m_ov;
    bit            m_done;
    int unsigned   ctx;
    bit            skip_data = 1'b0;
    int            tag_force = -1;
    bit            m_terr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] fill_word(input int v);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(v);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        part_n    = 0;
        delivered = 0;
        m_ov      = 1'b0;
        m_done    = 1'b0;
        m_terr    = 1'b0;
    endtask

    task automatic model_step(input bit iv, input logic [511:0] d, input bit fr, input int tag);
        bit full_m;
        bit quota;
        bit acc;
        bit hs;
        int slot;
        logic [4095:0] f;
        full_m = (mq.size() == 2);
        quota  = (ctx != 0) && (part_n == 0) && ((delivered + mq.size()) >= int'(ctx));
        acc    = iv && !full_m && !m_done && !quota;
        hs     = (mq.size() > 0) && fr;
        if (iv && !acc) m_ov = 1'b1;
        if (hs) begin
            void'(mq.pop_front());
            delivered++;
            if ((ctx != 0) && (delivered == int'(ctx))) m_done = 1'b1;
        end
        if (acc) begin
            slot = (tag >= 0) ? tag : part_n;
            if (slot != part_n) m_terr = 1'b1;
            part[slot] = d;
            part_n = slot + 1;
            if (part_n == 8) begin
                for (int p = 0; p < 8; p++) f[p*512 +: 512] = part[p];
                mq.push_back(f);
                part_n = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [4095:0] ef;
        logic [4095:0] af;
        int w;
        check("input_full",  64'(bus.input_full),  64'(mq.size() == 2));
        check("frame_valid", 64'(bus.frame_valid), 64'(mq.size() > 0));
        check("frame_index", 64'(bus.frame_index), 64'(delivered));
        check("done",        64'(bus.done),        64'(m_done));
        check("overflow",    64'(bus.overflow),    64'(m_ov));
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
        check("tag_error",   64'(bus.tag_error),   64'(m_terr));
`endif
        if (mq.size() > 0 && !skip_data) begin
            ef = mq[0];
            af = bus.frame_out;
            w  = 0;
            for (int i = 0; i < 128; i++) begin
                if (af[i*32 +: 32] !== ef[i*32 +: 32]) begin
                    w = i;
                    break;
                end
            end
            check($sformatf("frame_out_w%0d", w), 64'(af[w*32 +: 32]), 64'(ef[w*32 +: 32]));
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check just after it.
    task automatic cycle(input bit iv, input logic [511:0] d, input bit fr);
        int t;
        t = (tag_force >= 0) ? tag_force : part_n;
        bus.input_valid  = iv;
        bus.cacheline_in = d;
        bus.frame_ready  = fr;
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
        bus.plane_tag    = 3'(t);
`endif
        @(posedge clk);
        model_step(iv, d, fr, tag_force);
        #1;
        compare_all();
    endtask

    task automatic apply_reset(input int unsigned c);
        reset            = 1'b1;
        bus.input_valid  = 1'b0;
        bus.frame_ready  = 1'b0;
        bus.cacheline_in = '0;
        bus.ctx_length   = c;
        ctx              = c;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    int pulses;
    logic [511:0] first_beat;

    initial begin
        reset = 1'b1;
`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
        bus.plane_tag = 3'd0;
`endif

        // Single frame, ctx_length=1
        apply_reset(1);
        for (int p = 0; p < 8; p++) cycle(1'b1, fill_word(p + 1), 1'b1);
        check("t1_valid", 64'(bus.frame_valid), 64'd1);
        check("t1_plane3", 64'(bus.frame_out[3*512 +: 32]), 64'd4);
        check("t1_plane7", 64'(bus.frame_out[7*512 + 480 +: 32]), 64'd8);
        check("t1_index", 64'(bus.frame_index), 64'd0);
        cycle(1'b0, '0, 1'b1);
        check("t1_done", 64'(bus.done), 64'd1);
        cycle(1'b0, '0, 1'b1);

        // Backpressure, unlimited frames
        apply_reset(0);
        for (int b = 0; b < 16; b++) cycle(1'b1, rnd512(), 1'b0);
        check("t2_full", 64'(bus.input_full), 64'd1);
        cycle(1'b1, rnd512(), 1'b0);
        check("t2_overflow", 64'(bus.overflow), 64'd1);
        cycle(1'b0, '0, 1'b1);
        check("t2_full_after_rel", 64'(bus.input_full), 64'd0);
        check("t2_index1", 64'(bus.frame_index), 64'd1);
        cycle(1'b0, '0, 1'b1);
        check("t2_index2", 64'(bus.frame_index), 64'd2);

        // Back-to-back, ctx_length=3
        apply_reset(3);
        pulses = 0;
        for (int b = 0; b < 24; b++) begin
            cycle(1'b1, rnd512(), 1'b1);
            if (bus.frame_valid) pulses++;
        end
        check("t3_no_ovf", 64'(bus.overflow), 64'd0);
        cycle(1'b1, rnd512(), 1'b1);
        if (bus.frame_valid) pulses++;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, 1'b1);
            if (bus.frame_valid) pulses++;
        end
        check("t3_pulses", 64'(pulses), 64'd3);
        check("t3_done", 64'(bus.done), 64'd1);
        check("t3_ovf", 64'(bus.overflow), 64'd1);

        // Fill-complete and release in the same cycle
        apply_reset(0);
        for (int b = 0; b < 15; b++) cycle(1'b1, rnd512(), 1'b0);
        cycle(1'b1, rnd512(), 1'b1);
        check("t4_full", 64'(bus.input_full), 64'd0);
        check("t4_valid", 64'(bus.frame_valid), 64'd1);
        check("t4_index", 64'(bus.frame_index), 64'd1);
        cycle(1'b0, '0, 1'b1);

        // Asynchronous reset between edges
        apply_reset(0);
        for (int b = 0; b < 13; b++) cycle(1'b1, rnd512(), 1'b0);
        cycle(1'b1, rnd512(), 1'b1);
        cycle(1'b1, rnd512(), 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("t5_valid_async", 64'(bus.frame_valid), 64'd0);
        check("t5_index_async", 64'(bus.frame_index), 64'd0);
        check("t5_full_async",  64'(bus.input_full),  64'd0);
        model_reset();
        bus.input_valid = 1'b0;
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
        first_beat = rnd512();
        cycle(1'b1, first_beat, 1'b0);
        for (int b = 0; b < 7; b++) cycle(1'b1, rnd512(), 1'b0);
        check("t5_plane0", 64'(bus.frame_out[63:0]), first_beat[63:0]);
        check("t5_index", 64'(bus.frame_index), 64'd0);
        cycle(1'b0, '0, 1'b1);

        // Random traffic with varied frame quotas
        for (int r = 0; r < 4; r++) begin
            apply_reset($urandom_range(0, 4));
            for (int c = 0; c < 400; c++)
                cycle($urandom_range(0, 3) != 0, rnd512(), $urandom_range(0, 2) == 0);
        end

`ifdef FFT_PLANE_COLLECTOR_TAG_CHECK_EN
        // Tag resync: tags 0,1,2,5,6,7 still complete one frame
        apply_reset(0);
        skip_data = 1'b1;
        tag_force = 0; cycle(1'b1, rnd512(), 1'b0);
        tag_force = 1; cycle(1'b1, rnd512(), 1'b0);
        tag_force = 2; cycle(1'b1, rnd512(), 1'b0);
        check("t6_terr_clean", 64'(bus.tag_error), 64'd0);
        tag_force = 5; cycle(1'b1, rnd512(), 1'b0);
        check("t6_terr", 64'(bus.tag_error), 64'd1);
        tag_force = 6; cycle(1'b1, rnd512(), 1'b0);
        check("t6_not_valid", 64'(bus.frame_valid), 64'd0);
        tag_force = 7; cycle(1'b1, rnd512(), 1'b0);
        check("t6_valid", 64'(bus.frame_valid), 64'd1);
        tag_force = -1;
        cycle(1'b0, '0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
